shared_vc_port_tracker: RTL and testbench

Per-input-port tracker for shared-VC memory banks. It receives the one-hot bank grants and ready flags that each bank's allocator broadcasts, and keeps a registered record of which banks this port owns. It serves round-robin shared-VC allocation requests only from owned, allocation-ready banks. It also maintains this port's allocated-VC mask, which is fed back to every bank allocator as that port's slice of `allocated_ip_shared_ivc`.

---
 rtl/shared_vc_port_tracker.sv | 164 ++++++++++++++++
 tb/tb_shared_vc_port_tracker.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/shared_vc_port_tracker.sv
// -----------------------------------------------------------------------------
// shared_vc_port_tracker
//
// Per-input-port tracker for shared-VC memory banks. Latches which banks the
// bank allocators have granted to this port, serves round-robin shared-VC
// allocation requests from owned, allocation-ready banks, and keeps the
// port's allocated-VC mask that is fed back to every bank allocator.
//
// Parameters:
//   num_vcs   : shared VCs per port across all banks
//   num_ports : router ports (= number of banks)
//   port_id   : index of this port
//
// Ports:
//   clk                          rising-edge clock
//   reset                        asynchronous, active-low
//   memory_bank_grant_in         bank b one-hot grant at [b*num_ports +: num_ports]
//   ready_for_allocation_in      bit b = bank b accepts new allocations
//   alloc_req                    request one shared VC
//   alloc_gnt / alloc_vc         registered one-cycle grant and granted VC index
//   free_valid / free_vc         release of a VC
//   allocated_ip_shared_ivc_out  registered allocated mask (VC v in bank v/num_vcs_per_bank)
//   owned_banks                  registered bank ownership
//   err                          sticky protocol-error flag
//
// Build option: define SHARED_VC_PROTOCOL_CHECK_EN to enable the protocol
// checks driving err; otherwise err is tied low.
// -----------------------------------------------------------------------------
module shared_vc_port_tracker #(
    parameter int num_vcs   = 5,
    parameter int num_ports = 5,
    parameter int port_id   = 0,
    localparam int num_vcs_per_bank = num_vcs / num_ports,
    localparam int vc_idx_width     = (num_vcs > 1) ? $clog2(num_vcs) : 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [num_ports*num_ports-1:0] memory_bank_grant_in,
    input  logic [num_ports-1:0]           ready_for_allocation_in,
    input  logic                           alloc_req,
    output logic                           alloc_gnt,
    output logic [vc_idx_width-1:0]        alloc_vc,
    input  logic                           free_valid,
    input  logic [vc_idx_width-1:0]        free_vc,
    output logic [num_vcs-1:0]             allocated_ip_shared_ivc_out,
    output logic [num_ports-1:0]           owned_banks,
    output logic                           err
);

    // After reset bank port_id is granted to this port.
    localparam logic [num_ports-1:0] owned_rst_val = num_ports'(1) << port_id;

    logic [num_ports-1:0]    owned_q, owned_d;
    logic [num_ports-1:0]    ready_q;
    logic [num_vcs-1:0]      alloc_q, alloc_d;
    logic [num_vcs-1:0]      eligible;
    logic [vc_idx_width-1:0] rr_ptr_q, rr_ptr_d;
    logic                    alloc_gnt_q, alloc_gnt_d;
    logic [vc_idx_width-1:0] alloc_vc_q, alloc_vc_d;
    logic                    found;
    logic [vc_idx_width-1:0] pick;
    logic [vc_idx_width-1:0] idx_v;
    int                      idx;
    logic                    free_ok;

    // Only the column addressed to this port matters in each bank's grant.
    logic unused_grant_bits;
    assign unused_grant_bits = ^memory_bank_grant_in;

    genvar gi;
    generate
        for (gi = 0; gi < num_ports; gi++) begin : g_owned
            assign owned_d[gi] = memory_bank_grant_in[gi*num_ports + port_id];
        end
        for (gi = 0; gi < num_vcs; gi++) begin : g_elig
            localparam int bank = gi / num_vcs_per_bank;
            assign eligible[gi] = owned_q[bank] & ready_q[bank] & ~alloc_q[gi];
        end
    endgenerate

    assign free_ok = free_valid & (int'(free_vc) < num_vcs);

    // Round-robin search starting at rr_ptr, wrapping modulo num_vcs.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        idx_v = '0;
        for (int i = 0; i < num_vcs; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= num_vcs) idx = idx - num_vcs;
            idx_v = vc_idx_width'(idx);
            if (!found && eligible[idx_v]) begin
                found = 1'b1;
                pick  = idx_v;
            end
        end
    end

    always_comb begin
        alloc_d     = alloc_q;
        rr_ptr_d    = rr_ptr_q;
        alloc_gnt_d = 1'b0;
        alloc_vc_d  = alloc_vc_q;
        // Clear first so a grant in the same cycle is never lost; eligibility
        // already excludes a VC that was allocated before this edge.
        if (free_ok) alloc_d[free_vc] = 1'b0;
        if (alloc_req && found) begin
            alloc_d[pick] = 1'b1;
            alloc_gnt_d   = 1'b1;
            alloc_vc_d    = pick;
            rr_ptr_d      = (int'(pick) == num_vcs - 1) ? '0 : pick + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owned_q     <= owned_rst_val;
            ready_q     <= '1;
            alloc_q     <= '0;
            rr_ptr_q    <= '0;
            alloc_gnt_q <= 1'b0;
            alloc_vc_q  <= '0;
        end else begin
            owned_q     <= owned_d;
            ready_q     <= ready_for_allocation_in;
            alloc_q     <= alloc_d;
            rr_ptr_q    <= rr_ptr_d;
            alloc_gnt_q <= alloc_gnt_d;
            alloc_vc_q  <= alloc_vc_d;
        end
    end

    assign alloc_gnt                   = alloc_gnt_q;
    assign alloc_vc                    = alloc_vc_q;
    assign allocated_ip_shared_ivc_out = alloc_q;
    assign owned_banks                 = owned_q;

`ifdef SHARED_VC_PROTOCOL_CHECK_EN
    logic [num_ports-1:0] bank_busy;
    logic                 err_q, err_d;

    generate
        for (gi = 0; gi < num_ports; gi++) begin : g_busy
            assign bank_busy[gi] = |alloc_q[gi*num_vcs_per_bank +: num_vcs_per_bank];
        end
    endgenerate

    // Sticky: freeing an unallocated VC, or losing a bank that still holds VCs.
    assign err_d = err_q
                 | (free_ok & ~alloc_q[free_vc])
                 | (|(owned_q & ~owned_d & bank_busy));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_shared_vc_port_tracker.sv
module tb_shared_vc_port_tracker;

`ifdef SHARED_VC_PROTOCOL_CHECK_EN
    localparam int ERR_EN = 1;
`else
    localparam int ERR_EN = 0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [24:0] grant_in;
    logic [4:0]  ready_in;

    logic        req5, gnt5, fv5, err5;
    logic [2:0]  vc5, fvc5;
    logic [4:0]  mask5, own5;

    logic        req10, gnt10, fv10, err10;
    logic [3:0]  vc10, fvc10;
    logic [9:0]  mask10;
    logic [4:0]  own10;

    int checks   = 0;
    int failures = 0;

    typedef struct { int gnt; int vc; string tag; } exp_t;
    exp_t sb5[$];
    exp_t sb10[$];

    always #5 clk = ~clk;

    shared_vc_port_tracker #(.num_vcs(5), .num_ports(5), .port_id(0)) u5 (
        .clk(clk), .reset(reset),
        .memory_bank_grant_in(grant_in), .ready_for_allocation_in(ready_in),
        .alloc_req(req5), .alloc_gnt(gnt5), .alloc_vc(vc5),
        .free_valid(fv5), .free_vc(fvc5),
        .allocated_ip_shared_ivc_out(mask5), .owned_banks(own5), .err(err5)
    );

    shared_vc_port_tracker #(.num_vcs(10), .num_ports(5), .port_id(0)) u10 (
        .clk(clk), .reset(reset),
        .memory_bank_grant_in(grant_in), .ready_for_allocation_in(ready_in),
        .alloc_req(req10), .alloc_gnt(gnt10), .alloc_vc(vc10),
        .free_valid(fv10), .free_vc(fvc10),
        .allocated_ip_shared_ivc_out(mask10), .owned_banks(own10), .err(err10)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample 1 time unit after the edge, then retire scoreboard entries.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (sb5.size() > 0) begin
            e = sb5.pop_front();
            chk({e.tag, "_gnt"}, 32'(gnt5), e.gnt);
            chk({e.tag, "_vc"},  32'(vc5),  e.vc);
            $display("txn u5  %s gnt=%0d vc=%0d", e.tag, gnt5, vc5);
        end
        if (sb10.size() > 0) begin
            e = sb10.pop_front();
            chk({e.tag, "_gnt"}, 32'(gnt10), e.gnt);
            chk({e.tag, "_vc"},  32'(vc10),  e.vc);
            $display("txn u10 %s gnt=%0d vc=%0d", e.tag, gnt10, vc10);
        end
    endtask

    task automatic exp5(input int g, input int v, input string t);
        exp_t e; e.gnt = g; e.vc = v; e.tag = t; sb5.push_back(e);
    endtask

    task automatic exp10(input int g, input int v, input string t);
        exp_t e; e.gnt = g; e.vc = v; e.tag = t; sb10.push_back(e);
    endtask

    initial begin
        reset    = 1'b0;
        grant_in = '0;
        for (int b = 0; b < 5; b++) grant_in[b*5 + b] = 1'b1;
        ready_in = 5'b11111;
        req5 = 0; fv5 = 0; fvc5 = '0;
        req10 = 0; fv10 = 0; fvc10 = '0;

        // Reset state
        tick(); tick();
        chk("rst_mask5", 32'(mask5), 0);
        chk("rst_gnt5", 32'(gnt5), 0);
        chk("rst_vc5", 32'(vc5), 0);
        chk("rst_own5", 32'(own5), 32'h01);
        chk("rst_err5", 32'(err5), 0);
        chk("rst_mask10", 32'(mask10), 0);
        chk("rst_own10", 32'(own10), 32'h01);
        chk("rst_err10", 32'(err10), 0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // u5: bank 0 only holds VC 0
        req5 = 1;
        exp5(1, 0, "u5_req0"); tick();
        exp5(0, 0, "u5_req1"); tick();
        exp5(0, 0, "u5_req2"); tick();
        req5 = 0;
        chk("u5_mask_after", 32'(mask5), 32'h01);

        // Move bank 1 to port 0
        grant_in[5] = 1'b1;
        grant_in[6] = 1'b0;
        chk("own10_before", 32'(own10), 32'h01);
        tick();
        chk("own10_after", 32'(own10), 32'h03);
        chk("own5_after", 32'(own5), 32'h03);

        // u10: VCs 0..3 live in banks 0,1
        req10 = 1;
        exp10(1, 0, "u10_a0"); tick();
        exp10(1, 1, "u10_a1"); tick();
        exp10(1, 2, "u10_a2"); tick();
        exp10(1, 3, "u10_a3"); tick();
        exp10(0, 3, "u10_none"); tick();
        chk("u10_mask_full", 32'(mask10), 32'h00F);

        // Free VC 2 while requesting: not re-granted this cycle
        fv10 = 1; fvc10 = 4'd2;
        exp10(0, 3, "u10_free_req"); tick();
        fv10 = 0;
        chk("u10_mask_freed", 32'(mask10), 32'h00B);
        exp10(1, 2, "u10_wrap"); tick();
        req10 = 0;
        chk("u10_mask_wrap", 32'(mask10), 32'h00F);

        // Free VC 3 and drop bank 1 ready
        fv10 = 1; fvc10 = 4'd3; ready_in[1] = 1'b0;
        tick();
        fv10 = 0;
        chk("u10_mask_free3", 32'(mask10), 32'h007);
        req10 = 1; ready_in[1] = 1'b1;
        exp10(0, 2, "u10_notready"); tick();
        exp10(1, 3, "u10_ready_again"); tick();
        req10 = 0;
        chk("u10_mask_ready", 32'(mask10), 32'h00F);
        chk("u10_err_clean", 32'(err10), 0);

        // Free an unallocated VC
        fv10 = 1; fvc10 = 4'd7;
        tick();
        fv10 = 0;
        chk("u10_err_badfree", 32'(err10), ERR_EN);
        chk("u10_mask_badfree", 32'(mask10), 32'h00F);
        tick();
        chk("u10_err_sticky", 32'(err10), ERR_EN);

        // Out-of-range free on u5 is ignored
        fv5 = 1; fvc5 = 3'd6;
        tick();
        fv5 = 0;
        chk("u5_err_oor", 32'(err5), 0);
        chk("u5_mask_oor", 32'(mask5), 32'h01);

        // Bank 0 taken away while VC 0 is allocated
        grant_in[0] = 1'b0; grant_in[1] = 1'b1;
        tick();
        chk("u5_own_drop", 32'(own5), 32'h02);
        chk("u5_err_drop", 32'(err5), ERR_EN);

        // Reset asserted while alloc_gnt is high
        fv10 = 1; fvc10 = 4'd2;
        tick();
        fv10 = 0;
        req10 = 1;
        exp10(1, 2, "u10_pre_reset"); tick();
        req10 = 0;
        #2;
        reset = 1'b0;
        #1;
        chk("arst_gnt10", 32'(gnt10), 0);
        chk("arst_vc10", 32'(vc10), 0);
        chk("arst_mask10", 32'(mask10), 0);
        chk("arst_own10", 32'(own10), 32'h01);
        chk("arst_err10", 32'(err10), 0);
        chk("arst_mask5", 32'(mask5), 0);
        chk("arst_own5", 32'(own5), 32'h01);
        chk("arst_err5", 32'(err5), 0);
        chk("sb_empty", 32'(sb5.size() + sb10.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
